switch_toggle_bank: RTL and testbench

- Parametrised N-channel switch front end: synchronises raw mechanical switch inputs, debounces them per channel, and detects press and release edges.
- Drives one toggling LED bit per channel, with a selectable toggle edge.
- Sits directly between board switch pins and LED pins or user logic.
- Also exports one-cycle press/release event pulses, so downstream blocks need no local edge detection.

---
 rtl/switch_toggle_bank.sv | 119 +++++++++++
 tb/tb_switch_toggle_bank.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_toggle_bank.sv
// switch_toggle_bank
//    N-channel switch front end: per-channel input synchroniser, debounce
//    counter, registered press/release edge pulses and a toggling LED bit.
//
// Parameters
//    CHANNELS         number of independent switch/LED channels (1..32)
//    DEBOUNCE_CYCLES  consecutive differing samples needed to change level (>=2)
//    SYNC_STAGES      flops per input synchroniser (>=2)
//    EDGE_MODE        0 toggle on release, 1 on press, 2 on both, 3 LEDs follow level
//
// Ports
//    clock          system clock, all state on posedge
//    reset_n        asynchronous active-low reset
//    switches       raw asynchronous switch inputs, 1 = pressed
//    clear          synchronous clear of all LED bits (wins over a toggle)
//    leds           per-channel LED state
//    level          debounced switch level
//    press_pulse    one-cycle pulse after each debounced 0->1
//    release_pulse  one-cycle pulse after each debounced 1->0
//    any_event      OR of all press/release pulse bits, same cycle

module switch_toggle_bank #(
   parameter int unsigned CHANNELS        = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned EDGE_MODE       = 0
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] switches,
   input  logic                clear,
   output logic [CHANNELS-1:0] leds,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] press_pulse,
   output logic [CHANNELS-1:0] release_pulse,
   output logic                any_event
);

   localparam int unsigned       CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0] samp;
   logic [CNT_W-1:0]    cnt_q  [CHANNELS];
   logic [CHANNELS-1:0] level_d;
   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] fall;
   logic [CHANNELS-1:0] toggle;

   // Input synchroniser chain
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= switches;
         for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign samp = sync_q[SYNC_STAGES-1];

   // Debounce: a matching sample restarts the count; the final differing
   // sample commits the new level instead of incrementing, so it never wraps.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         level <= '0;
         for (int unsigned i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (samp[i] == level[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_MAX) begin
               level[i] <= samp[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // level_d lags level by one cycle, so rise/fall are true during the cycle
   // right after level changes; the pulses and LED toggle register that
   // together on the following edge.
   always_comb begin
      rise   = level & ~level_d;
      fall   = ~level & level_d;
      toggle = '0;
      case (EDGE_MODE)
         0:       toggle = fall;
         1:       toggle = rise;
         2:       toggle = rise | fall;
         default: toggle = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         level_d       <= '0;
         press_pulse   <= '0;
         release_pulse <= '0;
         any_event     <= 1'b0;
         leds          <= '0;
      end else begin
         level_d       <= level;
         press_pulse   <= rise;
         release_pulse <= fall;
         any_event     <= |(rise | fall);
         if (clear) begin
            leds <= '0;
         end else if (EDGE_MODE == 3) begin
            leds <= level;
         end else begin
            leds <= leds ^ toggle;
         end
      end
   end

endmodule

// File: tb/tb_switch_toggle_bank.sv
// Testbench for switch_toggle_bank: one DUT per EDGE_MODE sharing the same
// stimulus, compared every cycle against a behavioural model.

module tb_switch_toggle_bank;

   localparam int CH   = 4;
   localparam int DEB  = 4;
   localparam int SYNC = 2;

   logic          clock;
   logic          reset_n;
   logic [CH-1:0] switches;
   logic          clear;

   logic [CH-1:0] leds_w [4];
   logic [CH-1:0] lvl_w  [4];
   logic [CH-1:0] prs_w  [4];
   logic [CH-1:0] rel_w  [4];
   logic          any_w  [4];

   int n_checks = 0;
   int n_errors = 0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      switch_toggle_bank #(
         .CHANNELS        (CH),
         .DEBOUNCE_CYCLES (DEB),
         .SYNC_STAGES     (SYNC),
         .EDGE_MODE       (g)
      ) dut (
         .clock         (clock),
         .reset_n       (reset_n),
         .switches      (switches),
         .clear         (clear),
         .leds          (leds_w[g]),
         .level         (lvl_w[g]),
         .press_pulse   (prs_w[g]),
         .release_pulse (rel_w[g]),
         .any_event     (any_w[g])
      );
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   // Pin values travel through a SYNC-deep delay queue; each channel keeps a
   // run length of samples disagreeing with its level. A committed change is
   // reported (pulse, LED action) one edge later.
   bit [CH-1:0] m_pipe [$];
   bit [CH-1:0] m_level, m_rise_pend, m_fall_pend, m_press, m_release;
   bit          m_any;
   bit [CH-1:0] m_leds [4];
   int          m_streak [CH];

   task automatic model_reset();
      m_pipe = {};
      for (int k = 0; k < SYNC; k++) m_pipe.push_back('0);
      m_level = '0; m_rise_pend = '0; m_fall_pend = '0;
      m_press = '0; m_release = '0; m_any = 1'b0;
      for (int md = 0; md < 4; md++) m_leds[md] = '0;
      for (int c = 0; c < CH; c++) m_streak[c] = 0;
   endtask

   task automatic model_edge();
      bit [CH-1:0] s;
      s = m_pipe.pop_front();
      m_pipe.push_back(switches);
      m_press   = m_rise_pend;
      m_release = m_fall_pend;
      m_any     = |(m_rise_pend | m_fall_pend);
      for (int md = 0; md < 4; md++) begin
         if (clear)        m_leds[md] = '0;
         else if (md == 0) m_leds[md] = m_leds[md] ^ m_release;
         else if (md == 1) m_leds[md] = m_leds[md] ^ m_press;
         else if (md == 2) m_leds[md] = m_leds[md] ^ (m_press | m_release);
         else              m_leds[md] = m_level;
      end
      m_rise_pend = '0;
      m_fall_pend = '0;
      for (int c = 0; c < CH; c++) begin
         if (s[c] != m_level[c]) begin
            m_streak[c]++;
            if (m_streak[c] == DEB) begin
               m_level[c]  = s[c];
               m_streak[c] = 0;
               if (s[c]) m_rise_pend[c] = 1'b1;
               else      m_fall_pend[c] = 1'b1;
            end
         end else begin
            m_streak[c] = 0;
         end
      end
   endtask

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) model_reset();
      else          model_edge();
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      for (int m = 0; m < 4; m++) begin
         check($sformatf("level[m%0d]", m),   32'(lvl_w[m]),  32'(m_level));
         check($sformatf("press[m%0d]", m),   32'(prs_w[m]),  32'(m_press));
         check($sformatf("release[m%0d]", m), 32'(rel_w[m]),  32'(m_release));
         check($sformatf("any[m%0d]", m),     32'(any_w[m]),  32'(m_any));
         check($sformatf("leds[m%0d]", m),    32'(leds_w[m]), 32'(m_leds[m]));
      end
   endtask

   // Wait one cycle, check, then drive next inputs (on the falling edge).
   task automatic step(input logic [CH-1:0] sw, input logic clr);
      @(negedge clock);
      compare_all();
      switches = sw;
      clear    = clr;
   endtask

   task automatic do_reset();
      @(negedge clock);
      compare_all();
      reset_n  = 1'b0;
      switches = '0;
      clear    = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      int lat, np, nr, nboth, nany;
      logic [CH-1:0] rsw;

      reset_n  = 1'b0;
      switches = '0;
      clear    = 1'b0;
      repeat (2) @(negedge clock);
      compare_all();
      for (int m = 0; m < 4; m++) check("reset_leds", 32'(leds_w[m]), 32'd0);
      reset_n = 1'b1;

      // 1: clean press then release, latency from pin edge
      step(4'b0001, 1'b0);
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         step(4'b0001, 1'b0);
         if (prs_w[0][0]) begin lat = n; break; end
      end
      check("t1_press_latency", 32'(lat), 32'd7);
      check("t1_leds_after_press", 32'(leds_w[0][0]), 32'd0);
      repeat (3) step(4'b0001, 1'b0);
      repeat (12) step(4'b0000, 1'b0);
      check("t1_leds_after_release", 32'(leds_w[0][0]), 32'd1);

      // 2: bounce rejection on channel 1
      step(4'b0010, 1'b0); step(4'b0000, 1'b0);
      step(4'b0010, 1'b0); step(4'b0000, 1'b0);
      repeat (10) step(4'b0000, 1'b0);
      check("t2_bounce_level", 32'(lvl_w[0][1]), 32'd0);
      check("t2_bounce_leds", 32'(leds_w[1][1]), 32'd0);
      repeat (3) step(4'b0010, 1'b0);
      repeat (10) step(4'b0000, 1'b0);
      check("t2_short3_level", 32'(lvl_w[0][1]), 32'd0);
      check("t2_short3_leds", 32'(leds_w[1][1]), 32'd0);
      np = 0; nr = 0;
      for (int n = 0; n < 19; n++) begin
         step((n < 4) ? 4'b0010 : 4'b0000, 1'b0);
         np += int'(prs_w[0][1]);
         nr += int'(rel_w[0][1]);
      end
      check("t2_pulse4_presses", 32'(np), 32'd1);
      check("t2_pulse4_releases", 32'(nr), 32'd1);

      // 3: mode sweep on channel 2
      do_reset();
      repeat (10) step(4'b0100, 1'b0);
      check("t3_press_m0", 32'(leds_w[0][2]), 32'd0);
      check("t3_press_m1", 32'(leds_w[1][2]), 32'd1);
      check("t3_press_m2", 32'(leds_w[2][2]), 32'd1);
      check("t3_press_m3", 32'(leds_w[3][2]), 32'd1);
      repeat (12) step(4'b0000, 1'b0);
      check("t3_rel_m0", 32'(leds_w[0][2]), 32'd1);
      check("t3_rel_m1", 32'(leds_w[1][2]), 32'd1);
      check("t3_rel_m2", 32'(leds_w[2][2]), 32'd0);
      check("t3_rel_m3", 32'(leds_w[3][2]), 32'd0);

      // 4: simultaneous release on channels 0 and 3
      do_reset();
      repeat (12) step(4'b1001, 1'b0);
      nboth = 0; nany = 0;
      for (int n = 0; n < 12; n++) begin
         step(4'b0000, 1'b0);
         if (rel_w[0] == 4'b1001) nboth++;
         nany += int'(any_w[0]);
      end
      check("t4_joint_release", 32'(nboth), 32'd1);
      check("t4_any_cycles", 32'(nany), 32'd1);
      check("t4_leds", 32'(leds_w[0]), 32'h9);

      // 5: clear coincident with the release toggle
      do_reset();
      repeat (12) step(4'b0001, 1'b0);
      step(4'b0000, 1'b0);
      repeat (5) step(4'b0000, 1'b0);
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b0);
      check("t5_release_seen", 32'(rel_w[0][0]), 32'd1);
      check("t5_leds_cleared", 32'(leds_w[0][0]), 32'd0);
      repeat (4) step(4'b0000, 1'b0);

      // 6: async reset after two differing samples
      do_reset();
      step(4'b0001, 1'b0);
      repeat (4) step(4'b0001, 1'b0);
      reset_n = 1'b0;
      #1;
      for (int m = 0; m < 4; m++) begin
         check("t6_rst_level", 32'(lvl_w[m]), 32'd0);
         check("t6_rst_press", 32'(prs_w[m]), 32'd0);
         check("t6_rst_release", 32'(rel_w[m]), 32'd0);
         check("t6_rst_any", 32'(any_w[m]), 32'd0);
         check("t6_rst_leds", 32'(leds_w[m]), 32'd0);
      end
      repeat (2) step(4'b0001, 1'b0);
      @(negedge clock);
      compare_all();
      reset_n = 1'b1;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         step(4'b0001, 1'b0);
         if (prs_w[0][0]) begin lat = n; break; end
      end
      check("t6_press_latency", 32'(lat), 32'd7);
      repeat (3) step(4'b0001, 1'b0);
      check("t6_no_toggle_m0", 32'(leds_w[0][0]), 32'd0);

      // Randomised traffic: independent per-channel flips, occasional clear
      do_reset();
      rsw = '0;
      for (int n = 0; n < 600; n++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 4) == 0) rsw[c] = ~rsw[c];
         step(rsw, ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
      end
      repeat (12) step(rsw, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
